pwm_multi_channel: RTL and testbench

//  Parametrised multi-channel PWM generator; successor to the fixed 16-count, 50%-duty generator.
//  One shared period counter drives NUM_CH channels.

---
 rtl/pwm_multi_channel_pkg.sv | 23 ++
 rtl/pwm_channel_cmp.sv | 72 +++++++
 rtl/pwm_multi_channel.sv | 178 +++++++++++++++++
 tb/tb_pwm_multi_channel.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_multi_channel_pkg.sv
// Shared definitions for the multi-channel PWM generator.
//   ALIGN_EDGE / ALIGN_CENTER : alignment mode encodings (align_center input / shadow regs)
//   dir_e                     : counter direction in center-aligned mode
//   default_period()          : reset value of the period register (all ones for a given width)
package pwm_multi_channel_pkg;

  localparam logic ALIGN_EDGE   = 1'b0;
  localparam logic ALIGN_CENTER = 1'b1;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Reset period is the largest count the counter can hold: 2^w - 1.
  function automatic logic [31:0] default_period(input int unsigned w);
    if (w >= 32) begin
      return '1;
    end
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/pwm_channel_cmp.sv
// One PWM channel: double-buffered duty register plus the registered compare.
//   clk, rst_n   : clock, synchronous active-low reset
//   load         : capture duty into the pending register
//   pend         : a load is waiting since the last transfer (shared flag from the top)
//   xfer         : period boundary / idle transfer strobe; pending (or coincident load) -> active
//   out_en       : compare result is allowed onto pwm_out this cycle
//   align        : active alignment mode (ALIGN_EDGE / ALIGN_CENTER)
//   cnt          : shared period counter
//   duty         : duty value presented with load
//   pwm_out      : registered PWM output
module pwm_channel_cmp
  import pwm_multi_channel_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             pend,
  input  logic             xfer,
  input  logic             out_en,
  input  logic             align,
  input  logic [CNT_W-1:0] cnt,
  input  logic [CNT_W-1:0] duty,
  output logic             pwm_out
);

  logic [CNT_W-1:0] duty_pend_q;
  logic [CNT_W-1:0] duty_act_q;
  logic [CNT_W-1:0] duty_next;
  logic             hit;
  logic             pwm_q;

  // A load on the transfer edge bypasses the pending register.
  always_comb begin
    duty_next = duty_act_q;
    if (load) begin
      duty_next = duty;
    end else if (pend) begin
      duty_next = duty_pend_q;
    end
  end

  // Edge mode: high while cnt < D. Center mode: high while cnt <= D, which with each
  // count visited twice gives 2*D cycles centred on the period wrap.
  always_comb begin
    if (align == ALIGN_CENTER) begin
      hit = (cnt <= duty_act_q);
    end else begin
      hit = (cnt < duty_act_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      duty_pend_q <= '0;
      duty_act_q  <= '0;
      pwm_q       <= 1'b0;
    end else begin
      if (load) begin
        duty_pend_q <= duty;
      end
      if (xfer) begin
        duty_act_q <= duty_next;
      end
      pwm_q <= out_en & hit;
    end
  end

  assign pwm_out = pwm_q;

endmodule

// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM generator with one shared period counter.
//   clk          : sole clock, posedge
//   rst_n        : synchronous active-low reset
//   en           : 1 = run, 0 = counter and outputs idle (settings transfer every cycle)
//   load         : 1-cycle strobe capturing period/duty/align_center into pending registers
//   period       : terminal count P
//   duty         : per-channel duty, D[i] = duty[i*CNT_W +: CNT_W]
//   align_center : 0 = edge-aligned, 1 = center-aligned
//   pwm_out      : registered PWM outputs, one per channel
//   period_end   : high during the last count of each period
// Pending settings become active on the edge where period_end is high, on every idle
// cycle, and on the first edge after en rises (which restarts the period).
module pwm_multi_channel
  import pwm_multi_channel_pkg::*;
#(
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned NUM_CH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    load,
  input  logic [CNT_W-1:0]        period,
  input  logic [NUM_CH*CNT_W-1:0] duty,
  input  logic                    align_center,
  output logic [NUM_CH-1:0]       pwm_out,
  output logic                    period_end
);

  localparam logic [CNT_W-1:0] DefPeriod = CNT_W'(default_period(CNT_W));
  localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);

  // Counter state
  logic [CNT_W-1:0] cnt_q, cnt_d;
  dir_e             dir_q, dir_d;
  logic             run_q;

  // Period / alignment shadow registers
  logic [CNT_W-1:0] per_act_q, per_pend_q, per_next;
  logic             align_act_q, align_pend_q, align_next;
  logic             pend_q;

  logic             last_cnt;
  logic             xfer;
  logic             out_en;

  // ---------------------------------------------------------------------------
  // Settings that become active on a transfer edge; a load on that same edge wins.
  // ---------------------------------------------------------------------------
  always_comb begin
    per_next   = per_act_q;
    align_next = align_act_q;
    if (load) begin
      per_next   = period;
      align_next = align_center;
    end else if (pend_q) begin
      per_next   = per_pend_q;
      align_next = align_pend_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      per_pend_q   <= DefPeriod;
      per_act_q    <= DefPeriod;
      align_pend_q <= ALIGN_EDGE;
      align_act_q  <= ALIGN_EDGE;
      pend_q       <= 1'b0;
    end else begin
      if (load) begin
        per_pend_q   <= period;
        align_pend_q <= align_center;
      end
      if (xfer) begin
        per_act_q   <= per_next;
        align_act_q <= align_next;
        pend_q      <= 1'b0;
      end else if (load) begin
        pend_q <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Counter: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      dir_q <= DIR_UP;
      run_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      dir_q <= dir_d;
      run_q <= en;
    end
  end

  // ---------------------------------------------------------------------------
  // Counter: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_d = cnt_q;
    dir_d = dir_q;
    if (!en) begin
      cnt_d = '0;
      dir_d = DIR_UP;
    end else if (xfer) begin
      // New period, in whichever mode is about to become active.
      cnt_d = (align_next == ALIGN_CENTER) ? CntOne : '0;
      dir_d = DIR_UP;
    end else if (align_act_q == ALIGN_CENTER) begin
      unique case (dir_q)
        DIR_UP: begin
          // Turn-around: P is held for a second cycle.
          if (cnt_q == per_act_q) begin
            dir_d = DIR_DOWN;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
        DIR_DOWN: begin
          // cnt == 1 on the way down is the boundary, handled by xfer above.
          cnt_d = cnt_q - CntOne;
        end
        default: begin
          cnt_d = '0;
          dir_d = DIR_UP;
        end
      endcase
    end else begin
      cnt_d = cnt_q + CntOne;
    end
  end

  // ---------------------------------------------------------------------------
  // Counter: outputs decoded from registered state
  // ---------------------------------------------------------------------------
  always_comb begin
    if (align_act_q == ALIGN_CENTER) begin
      // P = 0 in center mode degenerates to a boundary every cycle.
      last_cnt = (per_act_q == '0) || ((dir_q == DIR_DOWN) && (cnt_q == CntOne));
    end else begin
      last_cnt = (cnt_q == per_act_q);
    end
  end

  // run_q keeps period_end low while idle and during the restart cycle after en rises.
  assign period_end = run_q & last_cnt;

  // Idle edges and the restart edge are transfer edges as well as the period boundary.
  assign xfer = ~en | ~run_q | period_end;

  // No compare result is valid while idle or on the restart edge; center mode with P = 0
  // is forced low.
  assign out_en = en & run_q & ~((align_act_q == ALIGN_CENTER) && (per_act_q == '0));

  // ---------------------------------------------------------------------------
  // Channels
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pwm_channel_cmp #(
      .CNT_W (CNT_W)
    ) u_cmp (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (load),
      .pend    (pend_q),
      .xfer    (xfer),
      .out_en  (out_en),
      .align   (align_act_q),
      .cnt     (cnt_q),
      .duty    (duty[i*CNT_W +: CNT_W]),
      .pwm_out (pwm_out[i])
    );
  end

endmodule

// File: tb/tb_pwm_multi_channel.sv
module tb_pwm_multi_channel;

  localparam int unsigned CW = 4;
  localparam int unsigned NC = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic             load;
  logic [CW-1:0]    period;
  logic [NC*CW-1:0] duty;
  logic             align_center;
  logic [NC-1:0]    pwm_out;
  logic             period_end;

  int checks = 0;
  int errors = 0;

  pwm_multi_channel #(
    .CNT_W  (CW),
    .NUM_CH (NC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .load         (load),
    .period       (period),
    .duty         (duty),
    .align_center (align_center),
    .pwm_out      (pwm_out),
    .period_end   (period_end)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model: tracks the position k within the current period and derives the
  // count value from it arithmetically.
  // ---------------------------------------------------------------------------
  int          m_p, m_al, p_p, p_al;
  int          m_d [NC];
  int          p_d [NC];
  bit          m_flag, m_run;
  int          m_k;
  logic [NC-1:0] m_out;

  function automatic int m_cnt();
    if (m_al != 0) return (m_k < m_p) ? m_k + 1 : 2 * m_p - m_k;
    return m_k;
  endfunction

  function automatic bit m_pe();
    if (!m_run) return 1'b0;
    if (m_al != 0) return (m_p == 0) || (m_k == 2 * m_p - 1);
    return m_k == m_p;
  endfunction

  function automatic void model_step(bit r, bit e, bit l, int p, logic [NC*CW-1:0] dv, bit al);
    bit xf;
    int c;
    if (!r) begin
      m_p = 2 ** CW - 1; p_p = m_p; m_al = 0; p_al = 0;
      for (int i = 0; i < NC; i++) begin m_d[i] = 0; p_d[i] = 0; end
      m_flag = 0; m_run = 0; m_k = 0; m_out = '0;
      return;
    end
    xf = !e || !m_run || m_pe();
    c  = m_cnt();
    for (int i = 0; i < NC; i++) begin
      if (!e || !m_run || (m_al != 0 && m_p == 0)) m_out[i] = 1'b0;
      else if (m_al != 0) m_out[i] = (c <= m_d[i]);
      else m_out[i] = (c < m_d[i]);
    end
    m_k = xf ? 0 : m_k + 1;
    if (l) begin
      p_p = p; p_al = al;
      for (int i = 0; i < NC; i++) p_d[i] = int'(dv[i*CW +: CW]);
    end
    if (xf) begin
      if (l || m_flag) begin
        m_p = p_p; m_al = p_al;
        for (int i = 0; i < NC; i++) m_d[i] = p_d[i];
      end
      m_flag = 0;
    end else if (l) begin
      m_flag = 1;
    end
    m_run = e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: model follows the inputs sampled at the edge, outputs compared 1 time unit later.
  task automatic tick();
    bit            c_r, c_e, c_l, c_a;
    int            c_p;
    logic [NC*CW-1:0] c_d;
    c_r = rst_n; c_e = en; c_l = load; c_a = align_center; c_p = int'(period); c_d = duty;
    @(posedge clk);
    model_step(c_r, c_e, c_l, c_p, c_d, c_a);
    #1;
    check("model pwm_out", 32'(pwm_out), 32'(m_out));
    check("model period_end", 32'(period_end), 32'(m_pe()));
  endtask

  task automatic set_in(input int p, input int d0, input int d1, input bit al);
    period       = CW'(p);
    duty         = {CW'(d1), CW'(d0)};
    align_center = al;
  endtask

  task automatic do_load();
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic wait_pe();
    for (int i = 0; i < 100; i++) begin
      if (period_end === 1'b1) return;
      tick();
    end
    check("period_end timeout", 32'(period_end), 32'd1);
  endtask

  // Measurement window helpers
  logic s0 [64];
  int   hi0, hi1, npe, first_pe;

  task automatic window(input int len);
    hi0 = 0; hi1 = 0; npe = 0; first_pe = -1;
    for (int j = 1; j <= len; j++) begin
      tick();
      s0[j-1] = pwm_out[0];
      if (pwm_out[0] === 1'b1) hi0++;
      if (pwm_out[1] === 1'b1) hi1++;
      if (period_end === 1'b1) begin
        npe++;
        if (first_pe < 0) first_pe = j;
      end
    end
  endtask

  function automatic int longest_run0(input int len);
    int run, best;
    run = 0; best = 0;
    for (int i = 0; i < 2 * len; i++) begin
      run  = (s0[i % len] === 1'b1) ? run + 1 : 0;
      best = (run > best) ? run : best;
    end
    return (best > len) ? len : best;
  endfunction

  typedef struct {
    int p; int d0; int d1; bit al; int win;
    int hi0; int hi1; int npe; int run0;
  } vec_t;

  vec_t vt [7];

  initial begin
    vt[0] = '{p: 15, d0: 8, d1: 4,  al: 0, win: 32, hi0: 16, hi1: 8,  npe: 2, run0: 8};
    vt[1] = '{p: 9,  d0: 0, d1: 12, al: 0, win: 10, hi0: 0,  hi1: 10, npe: 1, run0: 0};
    vt[2] = '{p: 5,  d0: 2, d1: 5,  al: 1, win: 10, hi0: 4,  hi1: 10, npe: 1, run0: 4};
    vt[3] = '{p: 0,  d0: 0, d1: 3,  al: 0, win: 4,  hi0: 0,  hi1: 4,  npe: 4, run0: 0};
    vt[4] = '{p: 0,  d0: 3, d1: 3,  al: 1, win: 4,  hi0: 0,  hi1: 0,  npe: 4, run0: 0};
    vt[5] = '{p: 3,  d0: 1, d1: 0,  al: 1, win: 6,  hi0: 2,  hi1: 0,  npe: 1, run0: 2};
    vt[6] = '{p: 7,  d0: 7, d1: 8,  al: 0, win: 8,  hi0: 7,  hi1: 8,  npe: 1, run0: 7};

    rst_n = 1'b0; en = 1'b0; load = 1'b0;
    set_in(0, 0, 0, 1'b0);
    tick();
    tick();
    check("reset pwm_out", 32'(pwm_out), 32'd0);
    check("reset period_end", 32'(period_end), 32'd0);
    rst_n = 1'b1;
    en    = 1'b1;

    // Table-driven steady-state patterns
    foreach (vt[n]) begin
      set_in(vt[n].p, vt[n].d0, vt[n].d1, vt[n].al);
      do_load();
      wait_pe();
      tick();
      window(vt[n].win);
      check($sformatf("row%0d high0", n), 32'(hi0), 32'(vt[n].hi0));
      check($sformatf("row%0d high1", n), 32'(hi1), 32'(vt[n].hi1));
      check($sformatf("row%0d period_end count", n), 32'(npe), 32'(vt[n].npe));
      check($sformatf("row%0d longest high run0", n), 32'(longest_run0(vt[n].win)),
            32'(vt[n].run0));
    end

    // Two loads within one period: current period unchanged, last load wins next period
    set_in(15, 10, 0, 1'b0);
    do_load();
    wait_pe();
    tick();
    hi0 = 0;
    for (int j = 1; j <= 16; j++) begin
      if (j == 5) begin set_in(15, 3, 0, 1'b0); load = 1'b1; end
      else if (j == 9) begin set_in(15, 6, 0, 1'b0); load = 1'b1; end
      else load = 1'b0;
      tick();
      if (pwm_out[0] === 1'b1) hi0++;
    end
    load = 1'b0;
    check("double load current period high0", 32'(hi0), 32'd10);
    window(16);
    check("double load next period high0", 32'(hi0), 32'd6);

    // en dropped mid-period with a pending load
    set_in(15, 8, 0, 1'b0);
    do_load();
    wait_pe();
    tick();
    repeat (5) tick();
    set_in(15, 2, 0, 1'b0);
    do_load();
    en = 1'b0;
    for (int j = 0; j < 3; j++) begin
      tick();
      check("idle pwm_out", 32'(pwm_out), 32'd0);
      check("idle period_end", 32'(period_end), 32'd0);
    end
    en = 1'b1;
    tick();
    window(16);
    check("re-enable high0", 32'(hi0), 32'd2);
    check("re-enable first period_end", 32'(first_pe), 32'd15);

    // Reset mid-period with a pending load
    set_in(15, 8, 0, 1'b0);
    do_load();
    wait_pe();
    tick();
    repeat (4) tick();
    set_in(5, 1, 1, 1'b1);
    do_load();
    repeat (2) tick();
    rst_n = 1'b0;
    tick();
    check("mid reset pwm_out", 32'(pwm_out), 32'd0);
    check("mid reset period_end", 32'(period_end), 32'd0);
    rst_n = 1'b1;
    tick();
    window(16);
    check("after reset high0", 32'(hi0), 32'd0);
    check("after reset high1", 32'(hi1), 32'd0);
    check("after reset first period_end", 32'(first_pe), 32'd15);

    // Randomised traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      en    = ($urandom_range(0, 19) != 0);
      load  = ($urandom_range(0, 7) == 0);
      set_in(($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : $urandom_range(0, 15),
             $urandom_range(0, 15), $urandom_range(0, 15), 1'($urandom_range(0, 1)));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
